addr_decode_router: RTL and testbench

Inbound decoder for the 27-bit global address. It accepts tagged read/write requests carrying an addr_t, splits the packed fields into a flat target descriptor and forwards it through a registered stage. Unmapped or out-of-range addresses get a tagged error response and are never forwarded. It sits between the PCIe/host request fabric and the per-target CSR/memory bridges.

---
 rtl/addr_decode_router_if.sv | 47 ++++
 rtl/addr_decode_router.sv | 154 +++++++++++++++
 tb/tb_addr_decode_router.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/addr_decode_router_if.sv
// addr_decode_router_if: request / decoded-target / error-response bundle for
// the global address decoder.
//   slave  : decoder side (takes req_*, drives tgt_*, err_*, req_rdy)
//   master : fabric side (drives req_*, tgt_rdy, err_rdy)
interface addr_decode_router_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic              req_vld;
  logic              req_rdy;
  logic [26:0]       req_addr;
  logic              req_wr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  logic              tgt_vld;
  logic              tgt_rdy;
  logic [1:0]        tgt_class;
  logic [2:0]        tgt_rack_id;
  logic [2:0]        tgt_zap_id;
  logic [3:0]        tgt_block_id;
  logic [2:0]        tgt_inst_id;
  logic [22:0]       tgt_offset;
  logic              tgt_wr;
  logic [DATA_W-1:0] tgt_wdata;
  logic [TAG_W-1:0]  tgt_tag;

  logic              err_vld;
  logic              err_rdy;
  logic [TAG_W-1:0]  err_tag;
  logic [1:0]        err_code;
  logic [15:0]       err_cnt;

  modport slave (
    input  req_vld, req_addr, req_wr, req_wdata, req_tag, tgt_rdy, err_rdy,
    output req_rdy, tgt_vld, tgt_class, tgt_rack_id, tgt_zap_id, tgt_block_id,
           tgt_inst_id, tgt_offset, tgt_wr, tgt_wdata, tgt_tag,
           err_vld, err_tag, err_code, err_cnt
  );

  modport master (
    output req_vld, req_addr, req_wr, req_wdata, req_tag, tgt_rdy, err_rdy,
    input  req_rdy, tgt_vld, tgt_class, tgt_rack_id, tgt_zap_id, tgt_block_id,
           tgt_inst_id, tgt_offset, tgt_wr, tgt_wdata, tgt_tag,
           err_vld, err_tag, err_code, err_cnt
  );
endinterface

// File: rtl/addr_decode_router.sv
// addr_decode_router: splits the packed 27-bit global address into a flat
// target descriptor and forwards it through one registered stage. Bad
// addresses are diverted to a separate registered error stage with a code
// and counted (saturating). One cycle accept-to-valid, full throughput.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : addr_decode_router_if.slave (req_*, tgt_*, err_*)
module addr_decode_router #(
  parameter int NUM_RACK = 8,
  parameter int TAG_W    = 6,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  addr_decode_router_if.slave  bus
);
  localparam logic [1:0] CL_ZAP_MEM = 2'd0;
  localparam logic [1:0] CL_ZAP_CSR = 2'd1;
  localparam logic [1:0] CL_NON_ZAP = 2'd2;
  localparam logic [1:0] CL_RACK    = 2'd3;

  localparam logic [1:0] EC_UNMAPPED = 2'd1;
  localparam logic [1:0] EC_BAD_RACK = 2'd2;
  localparam logic [1:0] EC_BAD_INST = 2'd3;

  localparam logic [3:0] RACK_LIM = 4'(NUM_RACK);

  typedef struct packed {
    logic [1:0]  cls;
    logic [2:0]  rack;
    logic [2:0]  zap;
    logic [3:0]  block;
    logic [2:0]  inst;
    logic [22:0] offset;
  } tgt_desc_t;

  // ---------------- decode ----------------
  logic [26:0] a;
  tgt_desc_t   d;
  logic        bad_rack, unmapped, bad_inst, is_err;
  logic [1:0]  code;

  assign a = bus.req_addr;

  always_comb begin
    d        = '0;
    bad_rack = 1'b0;
    unmapped = 1'b0;
    bad_inst = 1'b0;
    if (a[26]) begin
      d.rack   = a[24:22];
      d.zap    = a[21:19];
      bad_rack = {1'b0, a[24:22]} >= RACK_LIM;
      if (a[25]) begin
        d.cls    = CL_ZAP_CSR;
        d.block  = a[18:15];
        d.offset = {8'd0, a[14:0]};
        unmapped = a[18:15] inside {4'd0, 4'd13, 4'd14, 4'd15};
      end else begin
        d.cls    = CL_ZAP_MEM;
        d.offset = {4'd0, a[18:0]};
      end
    end else if (a[25:23] == 3'd6) begin
      // non-zap block 6 carries a second-level rack address in its offset
      d.cls    = CL_RACK;
      d.rack   = a[22:20];
      d.block  = {2'd0, a[19:18]};
      d.inst   = a[17:15];
      d.offset = {8'd0, a[14:0]};
      bad_rack = {1'b0, a[22:20]} >= RACK_LIM;
      unmapped = a[19:18] == 2'd3;
      bad_inst = (a[19:18] == 2'd0) && (a[17:15] != 3'd0);
    end else begin
      d.cls    = CL_NON_ZAP;
      d.block  = {1'b0, a[25:23]};
      d.offset = a[22:0];
      unmapped = a[25:23] == 3'd3;
    end
  end

  assign is_err = bad_rack | unmapped | bad_inst;
  assign code   = bad_rack ? EC_BAD_RACK : (unmapped ? EC_UNMAPPED : EC_BAD_INST);

  // ---------------- handshake ----------------
  logic tgt_vld_q, err_vld_q;
  logic free_tgt, free_err, acc;

  assign free_tgt    = !tgt_vld_q || bus.tgt_rdy;
  assign free_err    = !err_vld_q || bus.err_rdy;
  // Both stages must be free: the route is not known until decode, and
  // req_rdy must not depend on the request itself.
  assign bus.req_rdy = free_tgt && free_err;
  assign acc         = bus.req_vld && bus.req_rdy;

  // ---------------- tgt stage ----------------
  tgt_desc_t         tgt_q;
  logic              tgt_wr_q;
  logic [DATA_W-1:0] tgt_wdata_q;
  logic [TAG_W-1:0]  tgt_tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_vld_q   <= 1'b0;
      tgt_q       <= '0;
      tgt_wr_q    <= 1'b0;
      tgt_wdata_q <= '0;
      tgt_tag_q   <= '0;
    end else if (acc && !is_err) begin
      tgt_vld_q   <= 1'b1;
      tgt_q       <= d;
      tgt_wr_q    <= bus.req_wr;
      tgt_wdata_q <= bus.req_wdata;
      tgt_tag_q   <= bus.req_tag;
    end else if (bus.tgt_rdy) begin
      tgt_vld_q   <= 1'b0;
    end
  end

  // ---------------- err stage ----------------
  logic [TAG_W-1:0] err_tag_q;
  logic [1:0]       err_code_q;
  logic [15:0]      err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vld_q  <= 1'b0;
      err_tag_q  <= '0;
      err_code_q <= '0;
      err_cnt_q  <= '0;
    end else if (acc && is_err) begin
      err_vld_q  <= 1'b1;
      err_tag_q  <= bus.req_tag;
      err_code_q <= code;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end else if (bus.err_rdy) begin
      err_vld_q  <= 1'b0;
    end
  end

  assign bus.tgt_vld      = tgt_vld_q;
  assign bus.tgt_class    = tgt_q.cls;
  assign bus.tgt_rack_id  = tgt_q.rack;
  assign bus.tgt_zap_id   = tgt_q.zap;
  assign bus.tgt_block_id = tgt_q.block;
  assign bus.tgt_inst_id  = tgt_q.inst;
  assign bus.tgt_offset   = tgt_q.offset;
  assign bus.tgt_wr       = tgt_wr_q;
  assign bus.tgt_wdata    = tgt_wdata_q;
  assign bus.tgt_tag      = tgt_tag_q;
  assign bus.err_vld      = err_vld_q;
  assign bus.err_tag      = err_tag_q;
  assign bus.err_code     = err_code_q;
  assign bus.err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_addr_decode_router.sv
// tb_addr_decode_router: directed vectors against two decoders (NUM_RACK=8
// and NUM_RACK=4) fed from the same request stream.
module tb_addr_decode_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_vld = 1'b0;
  logic [26:0] req_addr = '0;
  logic        req_wr = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [5:0]  req_tag = '0;
  logic        tgt_rdy = 1'b1;
  logic        err_rdy = 1'b1;

  addr_decode_router_if #(.TAG_W(6), .DATA_W(32)) if8 ();
  addr_decode_router_if #(.TAG_W(6), .DATA_W(32)) if4 ();

  assign if8.req_vld = req_vld;   assign if4.req_vld = req_vld;
  assign if8.req_addr = req_addr; assign if4.req_addr = req_addr;
  assign if8.req_wr = req_wr;     assign if4.req_wr = req_wr;
  assign if8.req_wdata = req_wdata; assign if4.req_wdata = req_wdata;
  assign if8.req_tag = req_tag;   assign if4.req_tag = req_tag;
  assign if8.tgt_rdy = tgt_rdy;   assign if4.tgt_rdy = tgt_rdy;
  assign if8.err_rdy = err_rdy;   assign if4.err_rdy = err_rdy;

  addr_decode_router #(.NUM_RACK(8), .TAG_W(6), .DATA_W(32)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  addr_decode_router #(.NUM_RACK(4), .TAG_W(6), .DATA_W(32)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic put(input logic [26:0] a, input logic wr, input logic [31:0] wd, input logic [5:0] tg);
    req_vld = 1'b1; req_addr = a; req_wr = wr; req_wdata = wd; req_tag = tg;
  endtask

  // one-cycle request; returns at the negedge right after the load edge
  task automatic send(input logic [26:0] a, input logic wr, input logic [31:0] wd, input logic [5:0] tg);
    @(negedge clk); put(a, wr, wd, tg);
    @(negedge clk); req_vld = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_tgt_vld", 32'(if8.tgt_vld), 0);
    chk("rst_err_vld", 32'(if8.err_vld), 0);
    chk("rst_err_cnt", 32'(if8.err_cnt), 0);
    chk("rst_tgt_tag", 32'(if8.tgt_tag), 0);
    chk("rst_offset",  32'(if8.tgt_offset), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_req_rdy", 32'(if8.req_rdy), 1);

    // ZAP_CSR rack 2 zap 5 block 2
    send(27'h6A90123, 1'b0, 32'h0, 6'd5);
    chk("csr_vld",   32'(if8.tgt_vld), 1);
    chk("csr_class", 32'(if8.tgt_class), 1);
    chk("csr_rack",  32'(if8.tgt_rack_id), 2);
    chk("csr_zap",   32'(if8.tgt_zap_id), 5);
    chk("csr_block", 32'(if8.tgt_block_id), 2);
    chk("csr_off",   32'(if8.tgt_offset), 32'h123);
    chk("csr_tag",   32'(if8.tgt_tag), 5);
    chk("csr_noerr", 32'(if8.err_vld), 0);

    // non-zap block 3 unmapped
    send(27'h1800000, 1'b0, 32'h0, 6'd9);
    chk("nz3_err_vld", 32'(if8.err_vld), 1);
    chk("nz3_code",    32'(if8.err_code), 1);
    chk("nz3_tag",     32'(if8.err_tag), 9);
    chk("nz3_cnt",     32'(if8.err_cnt), 1);
    chk("nz3_no_tgt",  32'(if8.tgt_vld), 0);

    // RACK class, ICE with inst 1 -> BAD_INST; inst 0 -> good
    send(27'h3008000, 1'b0, 32'h0, 6'd3);
    chk("ice1_code", 32'(if8.err_code), 3);
    chk("ice1_cnt",  32'(if8.err_cnt), 2);
    send(27'h3000000, 1'b1, 32'hDEADBEEF, 6'd4);
    chk("ice0_vld",   32'(if8.tgt_vld), 1);
    chk("ice0_class", 32'(if8.tgt_class), 3);
    chk("ice0_block", 32'(if8.tgt_block_id), 0);
    chk("ice0_inst",  32'(if8.tgt_inst_id), 0);
    chk("ice0_off",   32'(if8.tgt_offset), 0);
    chk("ice0_wr",    32'(if8.tgt_wr), 1);
    chk("ice0_wdata", if8.tgt_wdata, 32'hDEADBEEF);
    chk("ice0_noerr", 32'(if8.err_vld), 0);

    // NON_ZAP block 2, full 23-bit offset
    send(27'h17FFFFF, 1'b0, 32'h0, 6'd6);
    chk("nz2_class", 32'(if8.tgt_class), 2);
    chk("nz2_block", 32'(if8.tgt_block_id), 2);
    chk("nz2_off",   32'(if8.tgt_offset), 32'h7FFFFF);

    // ZAP_CSR block 0 unmapped
    send(27'h6000000, 1'b0, 32'h0, 6'd2);
    chk("zb0_code", 32'(if8.err_code), 1);

    // ZAP_MEM rack 5: good at 8 racks, BAD_RACK at 4
    send(27'h5400000, 1'b0, 32'h0, 6'd7);
    chk("mem5_r8_class", 32'(if8.tgt_class), 0);
    chk("mem5_r8_rack",  32'(if8.tgt_rack_id), 5);
    chk("mem5_r4_err",   32'(if4.err_vld), 1);
    chk("mem5_r4_code",  32'(if4.err_code), 2);
    chk("mem5_r4_tag",   32'(if4.err_tag), 7);
    chk("mem5_r4_notgt", 32'(if4.tgt_vld), 0);
    send(27'h4C00000, 1'b0, 32'h0, 6'd8);
    chk("mem3_r4_vld",  32'(if4.tgt_vld), 1);
    chk("mem3_r4_class", 32'(if4.tgt_class), 0);
    chk("mem3_r4_rack", 32'(if4.tgt_rack_id), 3);

    // rack 5, rack block 3: BAD_RACK outranks UNMAPPED
    send(27'h35C0000, 1'b0, 32'h0, 6'd1);
    chk("prio_r8_code", 32'(if8.err_code), 1);
    chk("prio_r4_code", 32'(if4.err_code), 2);

    // backpressure: tgt_rdy low for 2 cycles
    @(negedge clk); tgt_rdy = 1'b0; put(27'h6A90123, 1'b0, 32'h0, 6'd10);
    @(negedge clk);
    chk("bp1_tag", 32'(if8.tgt_tag), 10);
    chk("bp1_rdy", 32'(if8.req_rdy), 0);
    put(27'h6A90123, 1'b0, 32'h0, 6'd11);
    @(negedge clk);
    chk("bp2_vld", 32'(if8.tgt_vld), 1);
    chk("bp2_tag", 32'(if8.tgt_tag), 10);
    chk("bp2_rdy", 32'(if8.req_rdy), 0);
    tgt_rdy = 1'b1;
    #1 chk("bp2_rdy_up", 32'(if8.req_rdy), 1);
    @(negedge clk);
    chk("bp3_tag", 32'(if8.tgt_tag), 11);
    put(27'h6A90123, 1'b0, 32'h0, 6'd12);
    @(negedge clk);
    chk("bp4_tag", 32'(if8.tgt_tag), 12);
    req_vld = 1'b0;
    @(negedge clk);
    chk("bp5_idle", 32'(if8.tgt_vld), 0);

    // error counter saturation: 65536 more errors on top of the ones above
    @(negedge clk); put(27'h1800000, 1'b0, 32'h0, 6'd9);
    repeat (65536) @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    chk("sat_cnt", 32'(if8.err_cnt), 32'hFFFF);

    // async reset with a held request
    @(negedge clk); tgt_rdy = 1'b0; put(27'h4C00000, 1'b0, 32'h0, 6'd20);
    @(negedge clk); req_vld = 1'b0;
    chk("ar_pre_vld", 32'(if8.tgt_vld), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_vld",  32'(if8.tgt_vld), 0);
    chk("ar_tag",  32'(if8.tgt_tag), 0);
    chk("ar_cnt",  32'(if8.err_cnt), 0);
    @(negedge clk); rst = 1'b0; tgt_rdy = 1'b1;
    @(negedge clk);
    chk("ar_gone", 32'(if8.tgt_vld), 0);
    chk("ar_rdy",  32'(if8.req_rdy), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
